branch_predictor_gshare: RTL

- Parametrised successor to the stub predictor in the fetch stage.
- Table of saturating counters (pattern history table, PHT) indexed by fetch PC, bimodal or gshare-hashed with a global history register (GHR).
- Two same-cycle lookup ports serve the dual-fetch slots.
- One update port, driven from execute, trains the counter and shifts the GHR when a branch resolves.

---
 rtl/branch_predictor_gshare.sv | 90 +++++++++
 1 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: a saturating-counter pattern history table
// with two combinational lookup ports and one non-speculative training port.
module branch_predictor_gshare #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 6,
    parameter bit GSHARE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bp_clear,
    input  logic [PC_W-1:0]  lk0_pc,
    input  logic [PC_W-1:0]  lk1_pc,
    output logic             lk0_taken,
    output logic             lk1_taken,
    output logic [GHR_W-1:0] lk_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    // History is zero-extended into the index so short histories only perturb the low bits.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [IDX_W-1:0] base,
                                                  input logic [GHR_W-1:0] hist);
        logic [IDX_W-1:0] hist_ext;
        hist_ext = '0;
        hist_ext[GHR_W-1:0] = hist;
        return GSHARE ? (base ^ hist_ext) : base;
    endfunction

    logic [CNT_W-1:0] pht [DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] ghr_next;

    logic [IDX_W-1:0] lk0_idx;
    logic [IDX_W-1:0] lk1_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] upd_cnt_next;

    // Only the word-index bits of each PC select an entry; the rest alias freely.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk0_pc, lk1_pc, upd_pc};

    assign lk0_idx = hash_idx(lk0_pc[IDX_W+1:2], ghr);
    assign lk1_idx = hash_idx(lk1_pc[IDX_W+1:2], ghr);
    assign upd_idx = hash_idx(upd_pc[IDX_W+1:2], upd_ghr);

    assign lk0_taken = pht[lk0_idx][CNT_W-1];
    assign lk1_taken = pht[lk1_idx][CNT_W-1];
    assign lk_ghr    = ghr;

    // Truncating the concatenation drops the oldest outcome, which also covers GHR_W == 1.
    assign ghr_next = GHR_W'({ghr, upd_taken});
    assign upd_cnt  = pht[upd_idx];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (upd_taken && (upd_cnt != CNT_MAX)) begin
            upd_cnt_next = upd_cnt + CNT_W'(1);
        end else if (!upd_taken && (upd_cnt != '0)) begin
            upd_cnt_next = upd_cnt - CNT_W'(1);
        end
    end

    // Clear shares the reset values and wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr <= '0;
        end else if (bp_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr <= '0;
        end else if (upd_valid) begin
            pht[upd_idx] <= upd_cnt_next;
            ghr          <= ghr_next;
        end
    end

endmodule
